mem_access_lsu: RTL and testbench
=================================

Name: mem_access_lsu

Overview:
- Memory-access stage load/store unit; the consumer of the execute stage's `mem_addr`, `ex_aluop` and `rt_data`.
- Decodes the memory opcode, checks alignment, and drives a req/ack data-memory port with byte enables.
- Formats load data with sign or zero extension and returns the register write-back tuple.
- Raises `stallreq` to freeze upstream stages while a memory transaction is outstanding.

Parameters:
- TIMEOUT, 16: maximum cycles in REQ waiting for `dmem_ack` before the access is aborted (legal range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute-stage result valid this cycle.
- ex_aluop  in  `AluOpBus  operation code; memory ops are `EXE_LB_OP/LH/LW/LBU/LHU/SB/SH/SW_OP` from defines.v.
- mem_addr  in  `MemAddrBus (32)  byte address.
- rt_data  in  `RegBus  store data.
- reg_waddr_i  in  `RegAddrBus  destination register.
- we_i  in  1  register write enable.
- reg_wdata_i  in  `RegBus  ALU result for non-memory ops.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {mem_addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  store data, replicated across lanes.
- dmem_ack  in  1  memory accepted or completed the request.
- dmem_rdata  in  32  read data, valid in the cycle `dmem_ack`=1.
- out_valid  out  1  write-back tuple valid, one-cycle pulse.
- reg_waddr_o  out  `RegAddrBus  destination register.
- we_o  out  1  register write enable.
- reg_wdata_o  out  `RegBus  write-back data.
- stallreq  out  1  freeze upstream stages.
- misalign  out  1  one-cycle pulse: misaligned access.
- timeout_err  out  1  one-cycle pulse: access aborted after TIMEOUT cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the timeout counter clears.
  - All outputs are 0, including `dmem_*`, `out_valid`, `we_o`, `reg_wdata_o`, `reg_waddr_o`, `misalign` and `timeout_err`.
  - Reset mid-transaction drops `dmem_req` immediately and produces no `out_valid`.
- FSM states: IDLE, REQ.
- `stallreq` (combinational):
  - 1 when state=REQ.
  - 1 when state=IDLE and `in_valid` is high with an aligned memory op.
  - 0 otherwise.
- IDLE with `in_valid`=0: `out_valid`=0 next cycle.
- IDLE, `in_valid`, non-memory op:
  - Next cycle `out_valid`=1, `reg_waddr_o`=`reg_waddr_i`, `we_o`=`we_i`, `reg_wdata_o`=`reg_wdata_i`.
  - Latency 1.
- IDLE, `in_valid`, misaligned memory op:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Next cycle `misalign`=1, `out_valid`=1, `we_o`=0, `reg_wdata_o`=0.
  - No `dmem_req` is issued and the state stays IDLE.
- IDLE, `in_valid`, aligned memory op:
  - Captures opcode, addr[1:0], `reg_waddr_i` and `we_i`.
  - Registers `dmem_addr`, `dmem_be`, `dmem_wdata` and `dmem_we`, then enters REQ.
  - `dmem_req`=1 from the next cycle.
- Store lane rules (lane n = addr[1:0]):
  - SB: be = 1<<n; wdata = {4{rt[7:0]}}.
  - SH: be = 4'b0011 when addr[1]=0, else 4'b1100; wdata = {2{rt[15:0]}}.
  - SW: be = 4'b1111; wdata = rt.
- Load byte enables: LB/LBU use the SB mask, LH/LHU use the SH mask, LW uses 4'b1111; `dmem_we`=0.
- REQ:
  - `dmem_req`, `dmem_addr`, `dmem_be`, `dmem_wdata` and `dmem_we` stay stable until the cycle `dmem_ack` is sampled high.
  - The counter increments every REQ cycle.
- `dmem_ack`=1 in REQ:
  - Next cycle: `dmem_req`=0, state=IDLE, `out_valid`=1.
  - Load result in `reg_wdata_o`:
    - LB / LBU: the selected byte `dmem_rdata`[8n+7:8n], sign- / zero-extended.
    - LH / LHU: the selected half, sign- / zero-extended.
    - LW: `dmem_rdata`.
  - Load `we_o`=captured `we_i`.
  - Store: `we_o`=0 and `reg_wdata_o`=0.
- Timeout:
  - If the counter reaches TIMEOUT-1 without ack, the next cycle drops `dmem_req`, pulses `timeout_err`=1 and `out_valid`=1 with `we_o`=0, and returns to IDLE.
  - Ack in the same cycle the counter hits TIMEOUT-1 takes priority, giving normal completion.
- Back-to-back: upstream holds its inputs while `stallreq`=1. `in_valid` seen in REQ is ignored; the held op is re-sampled in the IDLE cycle after completion.
- An ack arriving in IDLE is ignored.
- The counter clears on entry to REQ.

Test Plan:
- LW addr=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> `dmem_addr`=0x100, be=4'hF held 3 cycles; then `out_valid`=1, `reg_wdata_o`=0xDEADBEEF, `we_o`=1; `stallreq` high throughout.
- LB and LBU at addr=0x103, rdata=0x80123456 -> LB gives `reg_wdata_o`=0xFFFFFF80; LBU gives 0x00000080; be=4'b1000.
- SH at addr=0x202, rt=0x0000ABCD, ack after 1 cycle -> `dmem_we`=1, be=4'b1100, wdata=0xABCDABCD, `dmem_addr`=0x200; then `out_valid`=1, `we_o`=0.
- LW at addr=0x101 -> `misalign` pulse, no `dmem_req` ever asserted, `out_valid`=1, `we_o`=0; an ADD op (`reg_wdata_i`=5, `reg_waddr_i`=3) that follows passes through with 1-cycle latency.
- LW with `dmem_ack` never asserted, TIMEOUT=16 -> `dmem_req` high exactly 16 cycles; then `timeout_err`=1, `out_valid`=1, `we_o`=0; FSM back in IDLE.
- Assert rst=0 on the 2nd cycle of a pending SW -> `dmem_req` and `stallreq` go 0 asynchronously; no `out_valid` after release; the next LW completes normally.

Source files
------------

// File: rtl/mem_access_lsu.sv
// Memory-stage load/store unit: decode, alignment check, req/ack data port, load extension.
// Latency 1 for non-memory/misaligned ops; memory ops hold stallreq until ack or TIMEOUT abort.
module mem_access_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] rt_data,
  input  logic [4:0]  reg_waddr_i,
  input  logic        we_i,
  input  logic [31:0] reg_wdata_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [4:0]  reg_waddr_o,
  output logic        we_o,
  output logic [31:0] reg_wdata_o,
  output logic        stallreq,
  output logic        misalign,
  output logic        timeout_err
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        we_q, we_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  reg_waddr_o_q, reg_waddr_o_d;
  logic        we_o_q, we_o_d;
  logic [31:0] reg_wdata_o_q, reg_wdata_o_d;
  logic        misalign_q, misalign_d;
  logic        timeout_err_q, timeout_err_d;

  logic        is_byte, is_half, is_word, is_store, is_mem, is_mis;
  logic [3:0]  be_req;
  logic [31:0] wdata_req;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_store = 1'b0;
    case (ex_aluop)
      EXE_LB_OP, EXE_LBU_OP: is_byte = 1'b1;
      EXE_LH_OP, EXE_LHU_OP: is_half = 1'b1;
      EXE_LW_OP:             is_word = 1'b1;
      EXE_SB_OP: begin is_byte = 1'b1; is_store = 1'b1; end
      EXE_SH_OP: begin is_half = 1'b1; is_store = 1'b1; end
      EXE_SW_OP: begin is_word = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
    is_mem = is_byte | is_half | is_word;
    is_mis = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));

    if (is_word) begin
      be_req    = 4'b1111;
      wdata_req = rt_data;
    end else if (is_half) begin
      be_req    = mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata_req = {2{rt_data[15:0]}};
    end else begin
      be_req    = 4'b0001 << mem_addr[1:0];
      wdata_req = {4{rt_data[7:0]}};
    end
  end

  // Lane extraction uses the opcode/offset captured at issue, not the live inputs.
  always_comb begin
    byte_sel = dmem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      EXE_LB_OP:  load_data = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: load_data = {24'h0, byte_sel};
      EXE_LH_OP:  load_data = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: load_data = {16'h0, half_sel};
      EXE_LW_OP:  load_data = dmem_rdata;
      default:    load_data = 32'h0;
    endcase
  end

  assign stallreq = (state_q == REQ) || (in_valid && is_mem && !is_mis);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    lane_d        = lane_q;
    waddr_d       = waddr_q;
    we_d          = we_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_be_d     = dmem_be_q;
    dmem_wdata_d  = dmem_wdata_q;
    out_valid_d   = 1'b0;
    reg_waddr_o_d = reg_waddr_o_q;
    we_o_d        = we_o_q;
    reg_wdata_o_d = reg_wdata_o_q;
    misalign_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            out_valid_d   = 1'b1;
            reg_waddr_o_d = reg_waddr_i;
            we_o_d        = we_i;
            reg_wdata_o_d = reg_wdata_i;
          end else if (is_mis) begin
            out_valid_d   = 1'b1;
            misalign_d    = 1'b1;
            reg_waddr_o_d = reg_waddr_i;
            we_o_d        = 1'b0;
            reg_wdata_o_d = 32'h0;
          end else begin
            op_d         = ex_aluop;
            lane_d       = mem_addr[1:0];
            waddr_d      = reg_waddr_i;
            we_d         = we_i;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = {mem_addr[31:2], 2'b00};
            dmem_be_d    = be_req;
            dmem_wdata_d = wdata_req;
            cnt_d        = 8'h0;
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d       = IDLE;
          dmem_req_d    = 1'b0;
          out_valid_d   = 1'b1;
          reg_waddr_o_d = waddr_q;
          we_o_d        = we_q & ~dmem_we_q;
          reg_wdata_o_d = load_data;
        end else if (cnt_q == TMO_LAST) begin
          state_d       = IDLE;
          dmem_req_d    = 1'b0;
          out_valid_d   = 1'b1;
          timeout_err_d = 1'b1;
          reg_waddr_o_d = waddr_q;
          we_o_d        = 1'b0;
          reg_wdata_o_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'h0;
      op_q          <= 8'h0;
      lane_q        <= 2'b00;
      waddr_q       <= 5'h0;
      we_q          <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= 32'h0;
      dmem_be_q     <= 4'h0;
      dmem_wdata_q  <= 32'h0;
      out_valid_q   <= 1'b0;
      reg_waddr_o_q <= 5'h0;
      we_o_q        <= 1'b0;
      reg_wdata_o_q <= 32'h0;
      misalign_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      waddr_q       <= waddr_d;
      we_q          <= we_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_be_q     <= dmem_be_d;
      dmem_wdata_q  <= dmem_wdata_d;
      out_valid_q   <= out_valid_d;
      reg_waddr_o_q <= reg_waddr_o_d;
      we_o_q        <= we_o_d;
      reg_wdata_o_q <= reg_wdata_o_d;
      misalign_q    <= misalign_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_be     = dmem_be_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign out_valid   = out_valid_q;
  assign reg_waddr_o = reg_waddr_o_q;
  assign we_o        = we_o_q;
  assign reg_wdata_o = reg_wdata_o_q;
  assign misalign    = misalign_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_access_lsu.sv
// Scoreboard bench for mem_access_lsu: driver pushes expected write-back tuples and bus requests,
// a memory responder and an output monitor pop and compare them.
module tb_mem_access_lsu;
  localparam int TIMEOUT = 16;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_ADD = 8'b0010_0000;
  localparam logic [7:0] OP_OR  = 8'b0010_0101;

  logic        clk, rst, in_valid, we_i, dmem_req, dmem_we, dmem_ack;
  logic [7:0]  ex_aluop;
  logic [31:0] mem_addr, rt_data, reg_wdata_i, dmem_addr, dmem_wdata, dmem_rdata, reg_wdata_o;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  logic [3:0]  dmem_be;
  logic        out_valid, we_o, stallreq, misalign, timeout_err;

  mem_access_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ex_aluop(ex_aluop), .mem_addr(mem_addr),
    .rt_data(rt_data), .reg_waddr_i(reg_waddr_i), .we_i(we_i), .reg_wdata_i(reg_wdata_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .reg_waddr_o(reg_waddr_o), .we_o(we_o), .reg_wdata_o(reg_wdata_o),
    .stallreq(stallreq), .misalign(misalign), .timeout_err(timeout_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk_wa;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wdata;
    bit          mis;
    bit          tmo;
  } exp_t;

  typedef struct {
    int          delay;  // REQ cycle in which ack is given; 0 = never
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    bit          abort;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic int op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic bit op_signed(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  // Reference model: expected bus request and write-back tuple from the opcode rules.
  function automatic void model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                                input logic [4:0] wa, input logic we, input logic [31:0] wdi,
                                input int delay, input logic [31:0] rd, input bit abort,
                                output exp_t e, output bit use_mem, output mreq_t m);
    int sz, n;
    longint mask;
    logic [31:0] v;
    sz = op_size(op);
    n  = int'(addr[1:0]);
    use_mem = 0;
    m = '{0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 0};
    if (sz == 0) begin
      e = '{1, wa, we, wdi, 0, 0};
    end else if ((int'(addr[1:0]) % sz) != 0) begin
      e = '{0, wa, 1'b0, 32'h0, 1, 0};
    end else begin
      use_mem  = 1;
      m.delay  = delay;
      m.rdata  = rd;
      m.abort  = abort;
      m.addr   = addr - 32'(n);
      m.be     = 4'(((1 << sz) - 1) << n);
      m.we     = op_store(op);
      m.wdata  = (sz == 1) ? 32'(rt[7:0]) * 32'h0101_0101 :
                 (sz == 2) ? 32'(rt[15:0]) * 32'h0001_0001 : rt;
      if (delay == 0 || delay > TIMEOUT) begin
        e = '{0, wa, 1'b0, 32'h0, 0, 1};
      end else if (op_store(op)) begin
        e = '{0, wa, 1'b0, 32'h0, 0, 0};
      end else begin
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v = 32'((longint'(rd) >> (8 * n)) & mask);
        if (op_signed(op) && v[8 * sz - 1]) v = v | ~32'(mask);
        e = '{1, wa, we, v, 0, 0};
      end
    end
  endfunction

  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [4:0] wa, input logic we, input logic [31:0] wdi,
                       input int delay, input logic [31:0] rd, input bit garbage);
    exp_t e;
    mreq_t m;
    bit use_mem, done;
    model(op, addr, rt, wa, we, wdi, delay, rd, 0, e, use_mem, m);
    if (use_mem) mem_q.push_back(m);
    exp_q.push_back(e);
    in_valid = 1'b1; ex_aluop = op; mem_addr = addr; rt_data = rt;
    reg_waddr_i = wa; we_i = we; reg_wdata_i = wdi;
    done = 0;
    for (int c = 0; c < TIMEOUT + 8 && !done; c++) begin
      @(negedge clk);
      chk("stallreq", 32'(stallreq), (c == 0) ? 32'(use_mem) : 32'd1);
      @(posedge clk); #1;
      if (out_valid) done = 1;
      else if (garbage) begin
        in_valid = 1'($urandom_range(0, 1)); ex_aluop = 8'($urandom); mem_addr = $urandom;
        rt_data = $urandom; reg_waddr_i = 5'($urandom); we_i = 1'($urandom); reg_wdata_i = $urandom;
      end
    end
    if (!done) chk("op_complete", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Memory responder: checks each request against the model and acks in the scheduled REQ cycle.
  initial begin : responder
    mreq_t m;
    int n;
    bit fin;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!dmem_req) begin
        dmem_ack = rst && ($urandom_range(0, 5) == 0);
        dmem_rdata = $urandom;
      end else begin
        dmem_ack = 1'b0;
        if (mem_q.size() == 0) begin
          chk("unexpected_dmem_req", 32'(dmem_req), 32'd0);
          @(negedge dmem_req or negedge rst);
        end else begin
          m = mem_q.pop_front();
          chk("dmem_addr", dmem_addr, m.addr);
          chk("dmem_be", 32'(dmem_be), 32'(m.be));
          chk("dmem_we", 32'(dmem_we), 32'(m.we));
          if (m.we) chk("dmem_wdata", dmem_wdata, m.wdata);
          n = 1;
          fin = 0;
          while (!fin) begin
            if (m.delay == n) begin
              dmem_ack = 1'b1;
              dmem_rdata = m.rdata;
              @(posedge clk); #1;
              dmem_ack = 1'b0;
              dmem_rdata = $urandom;
              fin = 1;
            end else begin
              @(negedge clk);
              if (!dmem_req) begin
                if (!m.abort) chk("req_cycles", 32'(n), 32'(TIMEOUT));
                fin = 1;
              end else begin
                n++;
                chk("req_stable_addr", dmem_addr, m.addr);
                chk("req_stable_be", 32'(dmem_be), 32'(m.be));
                if (n > TIMEOUT + 2) begin
                  chk("req_overrun", 32'(n), 32'(TIMEOUT));
                  fin = 1;
                end
              end
            end
          end
        end
      end
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.chk_wa) chk("reg_waddr_o", 32'(reg_waddr_o), 32'(mon_e.wa));
          chk("we_o", 32'(we_o), 32'(mon_e.we));
          chk("reg_wdata_o", reg_wdata_o, mon_e.wdata);
          chk("misalign", 32'(misalign), 32'(mon_e.mis));
          chk("timeout_err", 32'(timeout_err), 32'(mon_e.tmo));
        end
      end else if (misalign || timeout_err) begin
        chk("pulse_without_out_valid", {30'h0, misalign, timeout_err}, 32'd0);
      end
    end
  end

  logic [7:0] ops [10];
  initial begin : driver
    exp_t e;
    mreq_t m;
    bit use_mem;
    logic [7:0] op;
    logic [31:0] addr;
    int r, dly, sz;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADD, OP_OR};
    rst = 1'b0; in_valid = 1'b0; ex_aluop = 8'h0; mem_addr = 32'h0; rt_data = 32'h0;
    reg_waddr_i = 5'h0; we_i = 1'b0; reg_wdata_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_we_o", 32'(we_o), 32'd0);
    chk("rst_reg_wdata_o", reg_wdata_o, 32'd0);
    chk("rst_reg_waddr_o", 32'(reg_waddr_o), 32'd0);
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    issue(OP_LW,  32'h0000_0100, 32'h0, 5'd7, 1'b1, 32'h0, 3, 32'hDEAD_BEEF, 0);
    issue(OP_LB,  32'h0000_0103, 32'h0, 5'd8, 1'b1, 32'h0, 2, 32'h8012_3456, 0);
    issue(OP_LBU, 32'h0000_0103, 32'h0, 5'd9, 1'b1, 32'h0, 1, 32'h8012_3456, 0);
    issue(OP_SH,  32'h0000_0202, 32'h0000_ABCD, 5'd1, 1'b1, 32'h0, 1, 32'h0, 0);
    issue(OP_LW,  32'h0000_0101, 32'h0, 5'd4, 1'b1, 32'h0, 1, 32'h0, 0);
    issue(OP_ADD, 32'h0, 32'h0, 5'd3, 1'b1, 32'd5, 0, 32'h0, 0);
    issue(OP_LW,  32'h0000_0104, 32'h0, 5'd5, 1'b1, 32'h0, 0, 32'h0, 1);
    issue(OP_LHU, 32'h0000_0302, 32'h0, 5'd6, 1'b1, 32'h0, TIMEOUT, 32'hF00D_8001, 1);
    issue(OP_LH,  32'h0000_0302, 32'h0, 5'd6, 1'b1, 32'h0, 2, 32'h8001_1234, 0);

    // Reset in the second REQ cycle of a store: bus drops at once, nothing is written back.
    model(OP_SW, 32'h0000_0400, 32'h1234_5678, 5'd2, 1'b0, 32'h0, 0, 32'h0, 1, e, use_mem, m);
    mem_q.push_back(m);
    in_valid = 1'b1; ex_aluop = OP_SW; mem_addr = 32'h0000_0400; rt_data = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("arst_dmem_req", 32'(dmem_req), 32'd0);
    chk("arst_stallreq", 32'(stallreq), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    issue(OP_LW, 32'h0000_0500, 32'h0, 5'd10, 1'b1, 32'h0, 2, 32'hCAFE_F00D, 0);

    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 9)];
      sz = op_size(op);
      addr = $urandom;
      if (sz > 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
      r = $urandom_range(0, 19);
      dly = (r == 0) ? 0 : (r == 1) ? TIMEOUT : 1 + (r % 5);
      issue(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom, dly, $urandom,
            bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        ex_aluop = 8'($urandom); mem_addr = $urandom;
        @(posedge clk); #1;
      end
    end

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
